// File: rtl/uart_bp_pkg.sv
// uart_bp_pkg: shared FSM states and mode encodings for the UART block processor
package uart_bp_pkg;
  typedef enum logic [1:0] {IDLE, RECV, SEND} state_e;
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_REV  = 2'd3;
endpackage

// File: rtl/byte_transform.sv
// byte_transform: per-byte output function selected by the latched block mode
module byte_transform
  import uart_bp_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic [1:0] mode_i,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);
  always_comb
    byte_o = mode_i == MODE_INV ? ~byte_i :
             mode_i == MODE_THR ? (byte_i >= THRESH ? 8'hFF : 8'h00) : byte_i;
endmodule

// File: rtl/uart_block_processor.sv
// uart_block_processor: collects BLK_N bytes from the UART, then retransmits them transformed
module uart_block_processor
  import uart_bp_pkg::*;
#(
  parameter int         BLK_N  = 32,
  parameter int         ADDR_W = 5,
  parameter logic [7:0] THRESH = 8'd128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic [1:0] mode,
  output logic       busy,
  output logic       block_done,
  output logic [7:0] blk_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLK_N - 1);
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q, idx;
  logic [1:0]        mode_q;
  logic [7:0]        mem_q [2**ADDR_W];
  logic [7:0]        tx_byte;
  byte_transform #(.THRESH(THRESH)) u_xf (
    .mode_i(mode_q),
    .byte_i(mem_q[idx]),
    .byte_o(tx_byte)
  );
  always_comb begin
    rd_uart = state_q == RECV && !rx_empty;
    wr_uart = state_q == SEND && !tx_full;
    busy    = state_q == SEND;
    idx     = mode_q == MODE_REV ? LAST - cnt_q : cnt_q;
    w_data  = busy ? tx_byte : 8'h00;
  end
  // buffer is deliberately left out of reset
  always_ff @(posedge clk)
    if (rd_uart) mem_q[cnt_q] <= r_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= MODE_PASS;
      blk_count  <= 8'd0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state_q)
        IDLE: state_q <= RECV;
        RECV: if (rd_uart) begin
          if (cnt_q == '0) mode_q <= mode;
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) state_q <= SEND;
        end
        SEND: if (wr_uart) begin
          cnt_q <= cnt_q == LAST ? '0 : cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) begin
            state_q    <= RECV;
            block_done <= 1'b1;
            blk_count  <= blk_count + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_block_processor.sv
// tb_uart_block_processor: randomized and directed checks against a block-level queue model
module tb_uart_block_processor;
  localparam int BLK_N = 4;
  localparam int ADDR_W = 2;
  logic clk = 1'b0;
  logic reset, rx_empty, tx_full, rd_uart, wr_uart, busy, block_done;
  logic [7:0] r_data, w_data, blk_count;
  logic [1:0] mode;
  uart_block_processor #(.BLK_N(BLK_N), .ADDR_W(ADDR_W), .THRESH(8'd128)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .mode(mode), .busy(busy),
    .block_done(block_done), .blk_count(blk_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [7:0] rx_q[$], exp_q[$], cur_q[$], log_q[$];
  int cur_mode, idle_left, model_blk, done_seen, wr_seen, p_rx, p_tx;
  bit done_pending, force_full, rand_mode, rst_prev;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] f(int m, logic [7:0] b);
    if (m == 1) return 8'd255 - b;
    if (m == 2) return (b >= 8'd128) ? 8'hFF : 8'h00;
    return b;
  endfunction
  task automatic cycle();
    bit in_send;
    rx_empty = rx_q.size() == 0 || ($urandom_range(99) < p_rx);
    r_data = rx_empty ? 8'($urandom) : rx_q[0];
    tx_full = force_full || ($urandom_range(99) < p_tx);
    if (rand_mode) mode = 2'($urandom);
    @(negedge clk);
    if (block_done === 1'b1) done_seen++;
    if (wr_uart === 1'b1) wr_seen++;
    if (reset) begin
      if (rst_prev) begin
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_blk_count", blk_count, 0);
      end
      if (rd_uart === 1'b1) void'(rx_q.pop_front());
      cur_q.delete(); exp_q.delete();
      idle_left = 1; model_blk = 0; done_pending = 0;
    end else begin
      in_send = exp_q.size() > 0;
      chk("rd_uart", rd_uart, !in_send && idle_left == 0 && !rx_empty);
      chk("wr_uart", wr_uart, in_send && !tx_full);
      chk("busy", busy, in_send);
      chk("w_data", w_data, in_send ? exp_q[0] : 8'h00);
      chk("block_done", block_done, done_pending);
      chk("blk_count", blk_count, model_blk % 256);
      done_pending = 0;
      if (idle_left > 0) idle_left--;
      else if (in_send) begin
        if (!tx_full) begin
          log_q.push_back(exp_q.pop_front());
          if (exp_q.size() == 0) begin done_pending = 1; model_blk++; end
        end
      end else if (!rx_empty) begin
        if (cur_q.size() == 0) cur_mode = int'(mode);
        cur_q.push_back(rx_q.pop_front());
        if (cur_q.size() == BLK_N) begin
          for (int i = 0; i < BLK_N; i++)
            exp_q.push_back(f(cur_mode, cur_q[cur_mode == 3 ? BLK_N - 1 - i : i]));
          cur_q.delete();
        end
      end
    end
    rst_prev = reset;
    @(posedge clk); #1;
  endtask
  task automatic run_until_log(int n);
    int t = 0;
    while (log_q.size() < n && t < 300) begin cycle(); t++; end
    if (log_q.size() < n) chk("timeout_log", log_q.size(), n);
  endtask
  task automatic directed(string name, logic [1:0] m, logic [31:0] rx, logic [31:0] tx);
    mode = m; log_q.delete();
    for (int i = 3; i >= 0; i--) rx_q.push_back(rx[i*8 +: 8]);
    run_until_log(4);
    cycle();
    for (int i = 0; i < 4; i++)
      chk(name, log_q.size() > i ? log_q[i] : 8'hxx, tx[(3-i)*8 +: 8]);
  endtask
  initial begin
    reset = 1'b1; mode = 2'd0; p_rx = 0; p_tx = 0; force_full = 0; rand_mode = 0;
    rst_prev = 0; done_seen = 0; wr_seen = 0; idle_left = 1; model_blk = 0;
    repeat (3) cycle();
    reset = 1'b0;
    directed("pass", 2'd0, 32'h01020304, 32'h01020304);
    chk("pass_blk_count", blk_count, 8'd1);
    chk("pass_done_pulses", done_seen, 1);
    directed("invert", 2'd1, 32'h00FF0FA5, 32'hFF00F05A);
    directed("thresh", 2'd2, 32'h7F8000FF, 32'h00FF00FF);
    directed("reverse", 2'd3, 32'h11223344, 32'h44332211);
    chk("blk_count_4", blk_count, 8'd4);
    // mode scrambled after the first pop, then tx stalled mid-block
    mode = 2'd1; log_q.delete();
    rx_q.push_back(8'h10);
    for (int t = 0; t < 50 && cur_q.size() == 0; t++) cycle();
    rand_mode = 1;
    rx_q.push_back(8'h20); rx_q.push_back(8'h30); rx_q.push_back(8'h40);
    run_until_log(2);
    rand_mode = 0; force_full = 1; wr_seen = 0;
    repeat (10) cycle();
    chk("stall_no_push", wr_seen, 0);
    force_full = 0;
    run_until_log(4);
    cycle();
    chk("stall_b0", log_q[0], 8'hEF);
    chk("stall_b1", log_q[1], 8'hDF);
    chk("stall_b2", log_q[2], 8'hCF);
    chk("stall_b3", log_q[3], 8'hBF);
    // reset after two of four bytes
    mode = 2'd0; log_q.delete();
    for (int i = 1; i <= 4; i++) rx_q.push_back(8'(i));
    for (int t = 0; t < 50 && cur_q.size() < 2; t++) cycle();
    p_rx = 100; reset = 1'b1; wr_seen = 0;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (3) cycle();
    chk("reset_no_tx", wr_seen, 0);
    p_rx = 0;
    rx_q.push_back(8'h05); rx_q.push_back(8'h06);
    run_until_log(4);
    cycle();
    for (int i = 0; i < 4; i++) chk("fresh_block", log_q[i], 8'(i + 3));
    chk("fresh_blk_count", blk_count, 8'd1);
    // randomized traffic until the block counter wraps
    reset = 1'b1; repeat (2) cycle(); reset = 1'b0;
    p_rx = 30; p_tx = 30; rand_mode = 1;
    for (int t = 0; t < 20000 && model_blk < 256; t++) begin
      while (rx_q.size() < 6) rx_q.push_back(8'($urandom));
      cycle();
    end
    p_rx = 100;
    cycle();
    chk("wrap_blocks", model_blk, 256);
    chk("wrap_blk_count", blk_count, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
